// File: rtl/sdram_pkg.sv
// Shared SDRAM control constants: arbiter state encoding, bank indices and the
// burst/refresh defaults that the command engine also relies on.
package sdram_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    READ    = 2'd2,
    REFRESH = 2'd3
  } state_t;

  localparam logic [1:0] BANK_A = 2'd0;
  localparam logic [1:0] BANK_B = 2'd1;

  localparam int DEF_BURST_LEN    = 4;
  localparam int DEF_REF_INTERVAL = 780;

  // Ping-pong partner of a frame bank.
  function automatic logic [1:0] other_bank(input logic [1:0] b);
    return (b == BANK_A) ? BANK_B : BANK_A;
  endfunction

endpackage

// File: rtl/sdram_ref_timer.sv
// Auto-refresh interval timer: raises a pending request every REF_INTERVAL
// cycles and records (sticky) when an interval expires with one still pending.
module sdram_ref_timer
  import sdram_pkg::*;
#(
  parameter int REF_INTERVAL = DEF_REF_INTERVAL
) (
  input  logic S_CLK,
  input  logic RST_N,
  input  logic refresh_ack,
  output logic ref_pending,
  output logic ref_overrun
);

  localparam int CNT_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

  logic [CNT_W-1:0] ref_cnt_q, ref_cnt_d;
  logic             ref_pending_q, ref_pending_d;
  logic             ref_overrun_q, ref_overrun_d;
  logic             wrap;

  // Next-state for the interval counter, pending flag and sticky overrun.
  always_comb begin
    wrap          = (ref_cnt_q == CNT_W'(REF_INTERVAL - 1));
    ref_cnt_d     = wrap ? '0 : ref_cnt_q + CNT_W'(1);
    ref_pending_d = ref_pending_q;
    ref_overrun_d = ref_overrun_q;
    if (refresh_ack) ref_pending_d = 1'b0;
    // A new interval always requests a refresh; if the previous one was never
    // serviced the request has been late by a full interval.
    if (wrap) begin
      ref_pending_d = 1'b1;
      if (ref_pending_q && !refresh_ack) ref_overrun_d = 1'b1;
    end
  end

  // Timer registers, cleared asynchronously.
  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      ref_cnt_q     <= '0;
      ref_pending_q <= 1'b0;
      ref_overrun_q <= 1'b0;
    end else begin
      ref_cnt_q     <= ref_cnt_d;
      ref_pending_q <= ref_pending_d;
      ref_overrun_q <= ref_overrun_d;
    end
  end

  assign ref_pending = ref_pending_q;
  assign ref_overrun = ref_overrun_q;

endmodule

// File: rtl/sdram_arbiter.sv
// Single-port SDRAM arbiter for a camera-to-display frame buffer: schedules
// write bursts, read bursts and auto-refresh, and ping-pongs frame banks so the
// reader only ever switches to a fully written frame.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int ADDR_W       = 20,
  parameter int BURST_LEN    = DEF_BURST_LEN,
  parameter int FRAME_WORDS  = 256,
  parameter int REF_INTERVAL = DEF_REF_INTERVAL
) (
  input  logic              S_CLK,
  input  logic              RST_N,
  input  logic              wr_req,
  input  logic              rd_req,
  output logic              write_en,
  output logic              read_en,
  output logic              refresh_en,
  input  logic              write_ack,
  input  logic              read_ack,
  input  logic              refresh_ack,
  output logic [ADDR_W-1:0] addr,
  output logic [1:0]        bank,
  output logic              wr_frame_done,
  output logic              rd_frame_done,
  output logic              ref_overrun
);

  state_t              state_q, state_d;
  state_t              last_served_q, last_served_d;
  logic                write_en_q, write_en_d;
  logic                read_en_q, read_en_d;
  logic                refresh_en_q, refresh_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          bank_q, bank_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [1:0]          wr_bank_q, wr_bank_d;
  logic [1:0]          rd_bank_q, rd_bank_d;
  logic                frame_ready_q, frame_ready_d;
  logic                wr_frame_done_q, wr_frame_done_d;
  logic                rd_frame_done_q, rd_frame_done_d;
  logic                grant_wr, grant_rd;
  logic                ref_pending;
  logic                ref_ack_valid;

  // Start address of the burst after the one at a.
  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(BURST_LEN);
  endfunction

  // True when the burst at a is the last one of the frame.
  function automatic logic frame_end(input logic [ADDR_W-1:0] a);
    return step_addr(a) == ADDR_W'(FRAME_WORDS);
  endfunction

  // Only a refresh_ack seen while refreshing counts.
  assign ref_ack_valid = refresh_ack && (state_q == REFRESH);

  sdram_ref_timer #(
    .REF_INTERVAL (REF_INTERVAL)
  ) u_ref_timer (
    .S_CLK       (S_CLK),
    .RST_N       (RST_N),
    .refresh_ack (ref_ack_valid),
    .ref_pending (ref_pending),
    .ref_overrun (ref_overrun)
  );

  // Arbitration decision and per-state completion bookkeeping.
  always_comb begin
    state_d         = state_q;
    last_served_d   = last_served_q;
    write_en_d      = write_en_q;
    read_en_d       = read_en_q;
    refresh_en_d    = refresh_en_q;
    addr_d          = addr_q;
    bank_d          = bank_q;
    wr_addr_d       = wr_addr_q;
    rd_addr_d       = rd_addr_q;
    wr_bank_d       = wr_bank_q;
    rd_bank_d       = rd_bank_q;
    frame_ready_d   = frame_ready_q;
    wr_frame_done_d = 1'b0;
    rd_frame_done_d = 1'b0;
    // Round-robin only matters when both requesters are asking at once.
    grant_wr        = 1'b0;
    grant_rd        = 1'b0;
    if (!ref_pending) begin
      if (wr_req && rd_req) begin
        grant_wr = (last_served_q != WRITE);
        grant_rd = (last_served_q == WRITE);
      end else begin
        grant_wr = wr_req;
        grant_rd = rd_req;
      end
    end

    case (state_q)
      IDLE: begin
        if (ref_pending) begin
          state_d      = REFRESH;
          refresh_en_d = 1'b1;
        end else if (grant_wr) begin
          state_d    = WRITE;
          write_en_d = 1'b1;
          addr_d     = wr_addr_q;
          bank_d     = wr_bank_q;
        end else if (grant_rd) begin
          state_d   = READ;
          read_en_d = 1'b1;
          addr_d    = rd_addr_q;
          bank_d    = rd_bank_q;
        end
      end
      WRITE: begin
        if (write_ack) begin
          state_d       = IDLE;
          write_en_d    = 1'b0;
          last_served_d = WRITE;
          if (frame_end(wr_addr_q)) begin
            wr_addr_d       = '0;
            wr_bank_d       = other_bank(wr_bank_q);
            frame_ready_d   = 1'b1;
            wr_frame_done_d = 1'b1;
          end else begin
            wr_addr_d = step_addr(wr_addr_q);
          end
        end
      end
      READ: begin
        if (read_ack) begin
          state_d       = IDLE;
          read_en_d     = 1'b0;
          last_served_d = READ;
          if (frame_end(rd_addr_q)) begin
            rd_addr_d       = '0;
            rd_frame_done_d = 1'b1;
            // Follow the writer only once it has finished a whole frame;
            // otherwise replay the current one.
            if (frame_ready_q) begin
              rd_bank_d     = other_bank(wr_bank_q);
              frame_ready_d = 1'b0;
            end
          end else begin
            rd_addr_d = step_addr(rd_addr_q);
          end
        end
      end
      REFRESH: begin
        if (refresh_ack) begin
          state_d      = IDLE;
          refresh_en_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs, all cleared asynchronously.
  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q         <= IDLE;
      last_served_q   <= READ;
      write_en_q      <= 1'b0;
      read_en_q       <= 1'b0;
      refresh_en_q    <= 1'b0;
      addr_q          <= '0;
      bank_q          <= '0;
      wr_addr_q       <= '0;
      rd_addr_q       <= '0;
      wr_bank_q       <= BANK_A;
      rd_bank_q       <= BANK_B;
      frame_ready_q   <= 1'b0;
      wr_frame_done_q <= 1'b0;
      rd_frame_done_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_served_q   <= last_served_d;
      write_en_q      <= write_en_d;
      read_en_q       <= read_en_d;
      refresh_en_q    <= refresh_en_d;
      addr_q          <= addr_d;
      bank_q          <= bank_d;
      wr_addr_q       <= wr_addr_d;
      rd_addr_q       <= rd_addr_d;
      wr_bank_q       <= wr_bank_d;
      rd_bank_q       <= rd_bank_d;
      frame_ready_q   <= frame_ready_d;
      wr_frame_done_q <= wr_frame_done_d;
      rd_frame_done_q <= rd_frame_done_d;
    end
  end

  assign write_en      = write_en_q;
  assign read_en       = read_en_q;
  assign refresh_en    = refresh_en_q;
  assign addr          = addr_q;
  assign bank          = bank_q;
  assign wr_frame_done = wr_frame_done_q;
  assign rd_frame_done = rd_frame_done_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: one instance carries burst traffic, a
// second with a 20-cycle refresh interval exercises the refresh timer.
module tb_sdram_arbiter;

  logic        S_CLK = 1'b0;
  logic        RST_N;
  logic        wr_req, rd_req, write_ack, read_ack, refresh_ack;
  logic        write_en, read_en, refresh_en;
  logic [19:0] addr;
  logic [1:0]  bank;
  logic        wr_frame_done, rd_frame_done, ref_overrun;

  logic        r_refresh_ack;
  logic        r_write_en, r_read_en, r_refresh_en;
  logic [19:0] r_addr;
  logic [1:0]  r_bank;
  logic        r_wr_frame_done, r_rd_frame_done, r_ref_overrun;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 S_CLK = ~S_CLK;

  sdram_arbiter #(.ADDR_W(20), .BURST_LEN(4), .FRAME_WORDS(256), .REF_INTERVAL(5000)) dut (
    .S_CLK(S_CLK), .RST_N(RST_N), .wr_req(wr_req), .rd_req(rd_req),
    .write_en(write_en), .read_en(read_en), .refresh_en(refresh_en),
    .write_ack(write_ack), .read_ack(read_ack), .refresh_ack(refresh_ack),
    .addr(addr), .bank(bank), .wr_frame_done(wr_frame_done),
    .rd_frame_done(rd_frame_done), .ref_overrun(ref_overrun)
  );

  sdram_arbiter #(.ADDR_W(20), .BURST_LEN(4), .FRAME_WORDS(256), .REF_INTERVAL(20)) rdut (
    .S_CLK(S_CLK), .RST_N(RST_N), .wr_req(1'b0), .rd_req(1'b0),
    .write_en(r_write_en), .read_en(r_read_en), .refresh_en(r_refresh_en),
    .write_ack(1'b0), .read_ack(1'b0), .refresh_ack(r_refresh_ack),
    .addr(r_addr), .bank(r_bank), .wr_frame_done(r_wr_frame_done),
    .rd_frame_done(r_rd_frame_done), .ref_overrun(r_ref_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({write_en, read_en, refresh_en, addr, bank, wr_frame_done, rd_frame_done, ref_overrun});
  endfunction

  // Wait (bounded) at negedges until the main DUT raises a burst command.
  task automatic wait_grant(input string tag);
    int n = 0;
    while (!(write_en || read_en) && n < 10) begin
      @(negedge S_CLK);
      n++;
    end
    if (!(write_en || read_en)) chk({tag, " timeout"}, 32'd0, 32'd1);
  endtask

  // One burst with a 2-cycle ack latency; checks grant, addr, bank, drop, frame pulse.
  task automatic burst(input logic is_wr, input int ea, input int eb, input logic efd, input string tag);
    wait_grant(tag);
    chk({tag, " grant"}, 32'({write_en, read_en}), is_wr ? 32'd2 : 32'd1);
    chk({tag, " addr"}, 32'(addr), 32'(ea));
    chk({tag, " bank"}, 32'(bank), 32'(eb));
    @(negedge S_CLK);
    if (is_wr) write_ack = 1'b1; else read_ack = 1'b1;
    @(negedge S_CLK);
    write_ack = 1'b0;
    read_ack  = 1'b0;
    chk({tag, " drop"}, 32'({write_en, read_en}), 32'd0);
    chk({tag, " fdone"}, 32'(is_wr ? wr_frame_done : rd_frame_done), 32'(efd));
  endtask

  task automatic do_reset(input logic w, input logic r);
    @(negedge S_CLK);
    RST_N  = 1'b0;
    wr_req = w;
    rd_req = r;
    @(negedge S_CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    write_ack = 1'b0; read_ack = 1'b0; refresh_ack = 1'b0; r_refresh_ack = 1'b0;
    repeat (2) @(negedge S_CLK);
    chk("reset outs", all_outs(), 32'd0);
    chk("reset ref outs", 32'({r_refresh_en, r_ref_overrun}), 32'd0);

    // Refresh timer: 20-cycle interval, no traffic.
    RST_N = 1'b1;
    repeat (20) @(negedge S_CLK);
    chk("ref en @20", 32'(r_refresh_en), 32'd0);
    @(negedge S_CLK);
    chk("ref en @21", 32'(r_refresh_en), 32'd1);
    r_refresh_ack = 1'b1;
    @(negedge S_CLK);
    r_refresh_ack = 1'b0;
    chk("ref ack clears", 32'(r_refresh_en), 32'd0);
    repeat (18) @(negedge S_CLK);
    chk("ref en @40", 32'(r_refresh_en), 32'd0);
    @(negedge S_CLK);
    chk("ref en @41", 32'(r_refresh_en), 32'd1);
    repeat (18) @(negedge S_CLK);
    chk("overrun @59", 32'(r_ref_overrun), 32'd0);
    @(negedge S_CLK);
    chk("overrun @60", 32'(r_ref_overrun), 32'd1);
    repeat (5) @(negedge S_CLK);
    chk("overrun held", 32'({r_ref_overrun, r_refresh_en}), 32'd3);
    r_refresh_ack = 1'b1;
    @(negedge S_CLK);
    r_refresh_ack = 1'b0;
    chk("overrun sticky", 32'({r_ref_overrun, r_refresh_en}), 32'd2);
    chk("ref dut no bursts", 32'({r_write_en, r_read_en, r_addr, r_bank, r_wr_frame_done, r_rd_frame_done}), 32'd0);
    chk("main no overrun", 32'(ref_overrun), 32'd0);

    // Writes from reset with wr_req held: one full frame plus one burst.
    do_reset(1'b1, 1'b0);
    chk("no grant during release", 32'(write_en), 32'd0);
    for (int k = 0; k < 65; k++)
      burst(1'b1, (k == 64) ? 0 : 4 * k, (k == 64) ? 1 : 0, k == 63, $sformatf("wr%0d", k));
    wr_req = 1'b0;
    rd_req = 1'b1;

    // Reads: bank 1 for a frame, then switch to the completed write bank 0.
    for (int k = 0; k < 65; k++)
      burst(1'b0, (k == 64) ? 0 : 4 * k, (k == 64) ? 0 : 1, k == 63, $sformatf("rd%0d", k));

    // Both requesting after a read: alternate starting with WRITE.
    wr_req = 1'b1;
    burst(1'b1, 4, 1, 1'b0, "rr w4");
    burst(1'b0, 4, 0, 1'b0, "rr r4");
    burst(1'b1, 8, 1, 1'b0, "rr w8");
    burst(1'b0, 8, 0, 1'b0, "rr r8");

    // Both requesting from reset: first grant is WRITE.
    do_reset(1'b1, 1'b1);
    burst(1'b1, 0, 0, 1'b0, "rst rr w0");
    burst(1'b0, 0, 1, 1'b0, "rst rr r0");
    burst(1'b1, 4, 0, 1'b0, "rst rr w4");
    burst(1'b0, 4, 1, 1'b0, "rst rr r4");

    // Read a full frame with no finished write frame: bank stays 1.
    do_reset(1'b0, 1'b1);
    for (int k = 0; k < 65; k++)
      burst(1'b0, (k == 64) ? 0 : 4 * k, 1, k == 63, $sformatf("rr%0d", k));

    // Mismatched ack ignored, then reset mid-write with a late ack.
    do_reset(1'b1, 1'b0);
    wait_grant("mis");
    @(negedge S_CLK);
    read_ack = 1'b1;
    @(negedge S_CLK);
    read_ack = 1'b0;
    chk("mismatched ack ignored", 32'({write_en, read_en}), 32'd2);
    write_ack = 1'b1;
    @(negedge S_CLK);
    write_ack = 1'b0;
    chk("mis drop", 32'(write_en), 32'd0);
    burst(1'b1, 4, 0, 1'b0, "after mis");
    wait_grant("mid");
    chk("mid addr", 32'(addr), 32'd8);
    RST_N  = 1'b0;
    wr_req = 1'b0;
    #1;
    chk("async reset outs", all_outs(), 32'd0);
    @(negedge S_CLK);
    RST_N     = 1'b1;
    write_ack = 1'b1;
    @(negedge S_CLK);
    write_ack = 1'b0;
    chk("late ack outs", all_outs(), 32'd0);
    wr_req = 1'b1;
    burst(1'b1, 0, 0, 1'b0, "post reset w0");
    wr_req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
